// File: rtl/soc_event_fifo_tx.sv
// SoC-side writer of the SoC-to-cluster event bus: round-robin arbitration of
// event sources into a Gray-pointer buffer read by the cluster domain.
module soc_event_fifo_tx #(
  parameter int unsigned N_SRC        = 4,
  parameter int unsigned EVNT_WIDTH   = 8,
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned DROP_ON_FULL = 0,
  localparam int unsigned PTR_W       = $clog2(DEPTH) + 1
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [N_SRC-1:0]            evt_valid_i,
  input  logic [N_SRC*EVNT_WIDTH-1:0] evt_id_i,
  output logic [N_SRC-1:0]            evt_ready_o,
  output logic [PTR_W-1:0]            evt_wptr_o,
  input  logic [PTR_W-1:0]            evt_rptr_i,
  output logic [DEPTH*EVNT_WIDTH-1:0] evt_data_o,
  output logic                        full_o,
  output logic                        empty_o,
  output logic [PTR_W-1:0]            level_o,
  input  logic                        drop_clr_i,
  output logic [15:0]                 drop_cnt_o
);

  localparam int unsigned RR_W  = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam logic [RR_W:0] N_SRC_W = (RR_W + 1)'(N_SRC);
  localparam logic DROP_EN = (DROP_ON_FULL != 0);

  logic [PTR_W-1:0]      rsync_q [SYNC_STAGES];
  logic [PTR_W-1:0]      rgray;
  logic [PTR_W-1:0]      rbin;
  logic [PTR_W-1:0]      wbin_q;
  logic [PTR_W-1:0]      wptr_q;
  logic [PTR_W-1:0]      level;
  logic [EVNT_WIDTH-1:0] buf_q [DEPTH];
  logic [EVNT_WIDTH-1:0] ids [N_SRC];
  logic [EVNT_WIDTH-1:0] win_id;
  logic [RR_W-1:0]       rr_q;
  logic [RR_W-1:0]       rr_d;
  logic [RR_W-1:0]       winner;
  logic [RR_W:0]         cand;
  logic [RR_W:0]         nxt;
  logic                  grant;
  logic                  accept;
  logic                  push;
  logic                  drop;
  logic                  full;
  logic [15:0]           drop_q;

  // The asynchronous read pointer goes straight into the synchroniser chain.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) rsync_q[i] <= '0;
    end else begin
      rsync_q[0] <= evt_rptr_i;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) rsync_q[i] <= rsync_q[i-1];
    end
  end

  assign rgray = rsync_q[SYNC_STAGES-1];

  always_comb begin
    rbin = '0;
    for (int unsigned i = 0; i < PTR_W; i++) rbin[i] = ^(rgray >> i);
  end

  assign level   = wbin_q - rbin;
  assign full    = (level == PTR_W'(DEPTH));
  assign full_o  = full;
  assign empty_o = (level == '0);
  assign level_o = level;

  always_comb begin
    for (int unsigned i = 0; i < N_SRC; i++) ids[i] = evt_id_i[i*EVNT_WIDTH +: EVNT_WIDTH];
  end

  // Search starts at rr_q and wraps; cand is kept one bit wider so the wrap
  // works for source counts that are not a power of two.
  always_comb begin
    grant  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      cand = {1'b0, rr_q} + (RR_W + 1)'(i);
      if (cand >= N_SRC_W) cand = cand - N_SRC_W;
      if (!grant && evt_valid_i[cand[RR_W-1:0]]) begin
        grant  = 1'b1;
        winner = cand[RR_W-1:0];
      end
    end
  end

  always_comb begin
    nxt = {1'b0, winner} + (RR_W + 1)'(1);
    if (nxt >= N_SRC_W) nxt = '0;
    rr_d = nxt[RR_W-1:0];
  end

  assign win_id = ids[winner];
  assign accept = grant && (!full || DROP_EN);
  assign push   = grant && !full;
  assign drop   = grant && full && DROP_EN;

  always_comb begin
    evt_ready_o = '0;
    if (accept) evt_ready_o[winner] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wbin_q <= '0;
      wptr_q <= '0;
      rr_q   <= '0;
      drop_q <= '0;
    end else begin
      // Published one cycle behind wbin so buffer data settles before the reader sees it.
      wptr_q <= wbin_q ^ (wbin_q >> 1);
      if (push)   wbin_q <= wbin_q + PTR_W'(1);
      if (accept) rr_q   <= rr_d;
      if (drop_clr_i)                 drop_q <= drop ? 16'd1 : 16'd0;
      else if (drop && drop_q != '1) drop_q <= drop_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned k = 0; k < DEPTH; k++) buf_q[k] <= '0;
    end else if (push) begin
      buf_q[wbin_q[IDX_W-1:0]] <= win_id;
    end
  end

  always_comb begin
    evt_data_o = '0;
    for (int unsigned k = 0; k < DEPTH; k++) evt_data_o[k*EVNT_WIDTH +: EVNT_WIDTH] = buf_q[k];
  end

  assign evt_wptr_o = wptr_q;
  assign drop_cnt_o = drop_q;

  level_legal: assert property (@(posedge clk_i) disable iff (!rst_ni) level <= PTR_W'(DEPTH));

endmodule

// File: tb/tb_soc_event_fifo_tx.sv
// Scoreboard bench for soc_event_fifo_tx: backpressure instance with a modelled
// reader, plus a drop-on-full instance checked against fixed expectations.
module tb_soc_event_fifo_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  valid, ready, wptr, rptr, level;
  logic [31:0] ids;
  logic [63:0] data;
  logic        full, empty, clr;
  logic [15:0] drop_cnt;
  logic [3:0]  d_valid, d_ready, d_wptr, d_rptr, d_level;
  logic [31:0] d_ids;
  logic [63:0] d_data;
  logic        d_full, d_empty, d_clr;
  logic [15:0] d_drop_cnt;

  int checks = 0;
  int failures = 0;

  // Reference model state
  int wcnt, wpub, rr, rcnt, rdrv, s1, s2, rd_lag;
  bit rd_en;
  logic [7:0] exp_q[$];
  logic [3:0] prev_wptr, last_ready;

  always #5 clk = ~clk;

  soc_event_fifo_tx #(
    .N_SRC(4), .EVNT_WIDTH(8), .DEPTH(8), .SYNC_STAGES(2), .DROP_ON_FULL(0)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .evt_valid_i(valid), .evt_id_i(ids),
    .evt_ready_o(ready), .evt_wptr_o(wptr), .evt_rptr_i(rptr), .evt_data_o(data),
    .full_o(full), .empty_o(empty), .level_o(level), .drop_clr_i(clr),
    .drop_cnt_o(drop_cnt)
  );

  soc_event_fifo_tx #(
    .N_SRC(4), .EVNT_WIDTH(8), .DEPTH(8), .SYNC_STAGES(2), .DROP_ON_FULL(1)
  ) dut_drop (
    .clk_i(clk), .rst_ni(rst_n), .evt_valid_i(d_valid), .evt_id_i(d_ids),
    .evt_ready_o(d_ready), .evt_wptr_o(d_wptr), .evt_rptr_i(d_rptr), .evt_data_o(d_data),
    .full_o(d_full), .empty_o(d_empty), .level_o(d_level), .drop_clr_i(d_clr),
    .drop_cnt_o(d_drop_cnt)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] gray(input int b);
    logic [3:0] x;
    x = 4'(b);
    return x ^ (x >> 1);
  endfunction

  task automatic model_reset();
    wcnt = 0; wpub = 0; rr = 0; rcnt = 0; rdrv = 0; s1 = 0; s2 = 0;
    prev_wptr = '0;
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    valid = '0; d_valid = '0; clr = 1'b0; d_clr = 1'b0;
    rptr = '0; d_rptr = '0;
    model_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  // One clock of the main instance: check at negedge, update model at posedge.
  task automatic step();
    int w, lvl;
    bit full_m;
    logic [3:0] er;
    @(negedge clk);
    lvl    = (wcnt - s2) & 15;
    full_m = (lvl == 8);
    w = -1;
    for (int i = 0; i < 4; i++) begin
      int j;
      j = (rr + i) % 4;
      if (w < 0 && valid[j]) w = j;
    end
    er = (w >= 0 && !full_m) ? 4'(1 << w) : 4'b0;
    last_ready = ready;
    check_eq("ready", ready, er);
    check_eq("level", level, lvl);
    check_eq("full", full, full_m);
    check_eq("empty", empty, lvl == 0);
    check_eq("wptr", wptr, gray(wpub));
    check_eq("wptr_flip", $countones(wptr ^ prev_wptr) <= 1, 1);
    check_eq("drop_cnt", drop_cnt, 0);
    prev_wptr = wptr;
    if (rd_en && ((wpub - rcnt) & 15) > rd_lag && exp_q.size() > 0) begin
      check_eq("rd_data", data[(rcnt % 8) * 8 +: 8], exp_q.pop_front());
      rcnt++;
    end
    @(posedge clk);
    wpub = wcnt & 15;
    if (er != 0) begin
      exp_q.push_back(ids[w*8 +: 8]);
      wcnt++;
      rr = (w + 1) % 4;
    end
    s2 = s1;
    s1 = rdrv & 15;
    #1;
    rdrv = rcnt;
    rptr = gray(rcnt);
  endtask

  initial begin
    int k;
    rst_n = 1'b0;
    valid = '0; ids = '0; clr = 1'b0; rptr = '0;
    d_valid = '0; d_ids = '0; d_clr = 1'b0; d_rptr = '0;
    rd_en = 1'b0; rd_lag = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_wptr", wptr, 0);
    check_eq("rst_empty", empty, 1);
    check_eq("rst_full", full, 0);
    check_eq("rst_ready", ready, 0);
    check_eq("rst_level", level, 0);
    check_eq("rst_data", data, 0);
    check_eq("rst_drop", drop_cnt, 0);
    rst_n = 1'b1;

    // Single push from source 2
    rd_en = 1'b1; rd_lag = 0;
    valid = 4'b0100; ids[23:16] = 8'h5A;
    step();
    check_eq("sp_ready", last_ready, 4'b0100);
    valid = '0;
    check_eq("sp_entry0", data[7:0], 8'h5A);
    check_eq("sp_level", level, 1);
    step();
    check_eq("sp_wptr", wptr, 4'h1);
    repeat (6) step();

    // Round-robin fill to full
    do_reset();
    rd_en = 1'b0;
    valid = 4'hF; ids = 32'h13121110;
    repeat (10) step();
    check_eq("rr_buf", data, 64'h13121110_13121110);
    check_eq("rr_full", full, 1);
    check_eq("rr_level", level, 8);

    // Backpressure, then free one slot
    valid = 4'b1000; ids[31:24] = 8'h99;
    repeat (2) step();
    check_eq("bp_ready", ready, 0);
    check_eq("bp_drop", drop_cnt, 0);
    check_eq("bp_head", data[7:0], exp_q.pop_front());
    rcnt = 1;
    step();
    k = 0;
    for (int t = 1; t <= 10; t++) begin
      step();
      if (last_ready != 0) begin
        k = t;
        break;
      end
    end
    check_eq("bp_latency", k, 3);
    valid = '0;
    check_eq("bp_entry0", data[7:0], 8'h99);
    rd_en = 1'b1;
    repeat (20) step();
    check_eq("bp_drained", empty, 1);

    // Wrap-around with reader trailing the writer
    do_reset();
    rd_en = 1'b1; rd_lag = 4;
    valid = 4'b0001;
    for (int t = 0; t < 60 && wcnt < 20; t++) begin
      ids[7:0] = 8'(8'h40 + wcnt);
      step();
    end
    valid = '0; rd_lag = 0;
    repeat (20) step();
    check_eq("wrap_wptr", wptr, gray(20));
    check_eq("wrap_empty", empty, 1);

    // Asynchronous reset at level 5
    do_reset();
    rd_en = 1'b0;
    valid = 4'b0010; ids[15:8] = 8'h77;
    repeat (5) step();
    valid = '0;
    check_eq("ar_level5", level, 5);
    #2 rst_n = 1'b0;
    #1;
    check_eq("ar_wptr", wptr, 0);
    check_eq("ar_empty", empty, 1);
    check_eq("ar_level", level, 0);
    check_eq("ar_data", data, 0);
    check_eq("ar_ready", ready, 0);
    do_reset();
    valid = 4'b0001; ids[7:0] = 8'hC3;
    step();
    valid = '0;
    check_eq("ar_entry0", data[7:0], 8'hC3);
    check_eq("ar_level1", level, 1);

    // Drop-on-full instance
    do_reset();
    d_valid = 4'b0001;
    for (int n = 0; n < 8; n++) begin
      d_ids[7:0] = 8'(8'h20 + n);
      #1 check_eq("dp_fill_ready", d_ready, 4'b0001);
      @(posedge clk); #1;
    end
    d_valid = '0;
    #1;
    check_eq("dp_full", d_full, 1);
    check_eq("dp_level", d_level, 8);
    d_valid = 4'b0010; d_ids[15:8] = 8'hEE;
    repeat (5) begin
      #1 check_eq("dp_ready", d_ready, 4'b0010);
      @(posedge clk); #1;
    end
    check_eq("dp_cnt5", d_drop_cnt, 5);
    check_eq("dp_wptr", d_wptr, gray(8));
    d_clr = 1'b1;
    #1 check_eq("dp_clr_ready", d_ready, 4'b0010);
    @(posedge clk); #1;
    check_eq("dp_clr_drop", d_drop_cnt, 1);
    d_valid = '0;
    @(posedge clk); #1;
    check_eq("dp_clr_only", d_drop_cnt, 0);
    d_clr = 1'b0;
    d_valid = 4'b1010; d_ids[31:24] = 8'hAB;
    #1 check_eq("dp_onehot", d_ready, 4'b1000);
    @(posedge clk); #1;
    d_valid = '0;
    check_eq("dp_cnt1", d_drop_cnt, 1);
    check_eq("dp_wptr_hold", d_wptr, gray(8));
    check_eq("dp_entry0", d_data[7:0], 8'h20);
    check_eq("dp_entry7", d_data[63:56], 8'h27);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/soc_event_fifo_tx.md
Name: soc_event_fifo_tx

Overview:
- Parametrised SoC-side writer for the SoC-to-cluster event bus.
- Round-robin arbitrates N_SRC event sources and stores event IDs in a DEPTH-entry buffer.
- Exposes a Gray-coded write pointer and the full buffer contents to the cluster-side reader.
- Resynchronises the reader's Gray read pointer for flow control.
- Generalises the fixed 8-entry event bus with: configurable depth and source count, drop-on-full mode, occupancy reporting and a drop counter.

Parameters:
- N_SRC, 4, number of event sources (1..16)
- EVNT_WIDTH, 8, event ID width
- DEPTH, 8, buffer entries; power of two, ≥2
- SYNC_STAGES, 2, flops on the read-pointer synchroniser (≥2)
- DROP_ON_FULL, 0, 0 = backpressure sources when full; 1 = acknowledge and discard the winner when full
- PTR_W, $clog2(DEPTH)+1, pointer width (derived, not overridable)

Ports:
- clk_i  in  1  SoC clock
- rst_ni  in  1  asynchronous active-low reset
- evt_valid_i  in  N_SRC  per-source event request
- evt_id_i  in  N_SRC*EVNT_WIDTH  per-source event ID; source i at bits [i*EVNT_WIDTH +: EVNT_WIDTH]
- evt_ready_o  out  N_SRC  per-source acknowledge; transfer when valid & ready
- evt_wptr_o  out  PTR_W  Gray-coded write pointer to the cluster domain
- evt_rptr_i  in  PTR_W  Gray-coded read pointer from the cluster domain (asynchronous)
- evt_data_o  out  DEPTH*EVNT_WIDTH  flattened buffer; entry k at [k*EVNT_WIDTH +: EVNT_WIDTH]
- full_o  out  1  buffer full (SoC view)
- empty_o  out  1  buffer empty (SoC view)
- level_o  out  PTR_W  occupancy, 0..DEPTH
- drop_clr_i  in  1  synchronous clear of the drop counter
- drop_cnt_o  out  16  saturating count of discarded events

Behaviour:
- Clock and reset: one clock (clk_i); reset rst_ni is asynchronous, active-low.
- Reset values: all outputs and internal state are 0, i.e. pointers, sync flops, buffer, RR pointer, drop counter. Consequently empty_o=1, full_o=0, evt_ready_o=0.
- Read-pointer synchroniser:
  - evt_rptr_i passes through SYNC_STAGES flops, then Gray-to-binary conversion → rbin.
  - No other logic touches evt_rptr_i before the sync.
- Write pointer:
  - Internal binary wbin, PTR_W bits, wraps modulo 2^PTR_W.
  - level = wbin - rbin (modulo 2^PTR_W).
  - full_o = (level == DEPTH); empty_o = (level == 0); level_o = level.
  - All three are combinational from registered state.
- Arbitration:
  - Round-robin over evt_valid_i, starting the search at rr_ptr.
  - Winner = first valid index at or after rr_ptr, wrapping.
  - At most one grant per cycle.
  - After any grant, rr_ptr <= winner+1 mod N_SRC. With no grant, rr_ptr holds.
- Handshake:
  - evt_ready_o is combinational: one-hot on the winner, all zero when no valid.
  - DROP_ON_FULL=0: evt_ready_o is all zero while full_o=1, and rr_ptr does not advance.
  - DROP_ON_FULL=1: the winner is acknowledged even when full; the event is discarded and drop_cnt_o increments. Non-winners are never acknowledged or dropped.
- Push: on a non-dropped transfer at edge t:
  - buffer[wbin[PTR_W-2:0]] <= winner ID;
  - wbin <= wbin+1.
- Pointer publication:
  - evt_wptr_o <= bin2gray(wbin), registered one cycle after wbin updates.
  - This guarantees data is stable ≥1 cycle before the pointer can be seen.
  - Push-to-visible latency is 2 cycles.
  - full/level use wbin, not the published pointer.
- evt_data_o is the registered buffer contents.
- Throughput: one push per cycle, sustained while not full.
- Drop counter:
  - Saturates at 16'hFFFF.
  - drop_clr_i together with a drop in the same cycle → counter = 1.
  - drop_clr_i alone → 0.
- Simultaneous push and read-pointer advance:
  - full/level reflect both on the next cycle.
  - A slot freed by the reader becomes usable SYNC_STAGES+1 cycles after evt_rptr_i changes.
- Reset asserted mid-operation:
  - Immediate asynchronous return to reset values; in-flight events are lost.
  - The reader must be reset concurrently.
- Reader pointer beyond writer (level > DEPTH) is illegal; simulation assertion flags it, hardware behaviour undefined.
- N_SRC=1: arbiter degenerates to a pass-through; rr_ptr is a constant 0.

Test Plan:
All scenarios use N_SRC=4, DEPTH=8, EVNT_WIDTH=8, SYNC_STAGES=2.
- Reset/single push: hold rst_ni=0, then release. Expect evt_wptr_o=0, empty_o=1. Set src2 valid, ID 0x5A, for 1 cycle → ready_o=4'b0100 that cycle; entry0=0x5A after 1 edge; evt_wptr_o=Gray(1)=1 after 2 edges; level_o=1.
- Round-robin fairness: all four sources valid continuously with IDs 0x10..0x13 → grant order 0,1,2,3,0,1,… The buffer holds 0x10,0x11,0x12,0x13,0x10,… until full at level 8.
- Backpressure (DROP_ON_FULL=0): fill 8 entries while evt_rptr_i stays 0 → full_o=1, ready_o=0, drop_cnt_o=0. Drive evt_rptr_i=Gray(1) → ready reasserts 3 cycles later; the 9th event is written into entry 0.
- Drop mode (DROP_ON_FULL=1): when full, src1 valid for 5 cycles → ready_o[1]=1 each cycle, drop_cnt_o=5, wptr unchanged. Pulse drop_clr_i together with a 6th drop → drop_cnt_o=1.
- Wrap-around: push 20 events while the reader follows 4 entries behind → evt_wptr_o sequences through Gray 0..15 and wraps to 0. Entry index = count mod 8; level_o never exceeds 8; the wptr_o change between consecutive cycles is always a single-bit flip.
- Async reset mid-stream: assert rst_ni at level 5 between clock edges → all outputs are 0/empty immediately, without waiting for an edge. After release, the first push lands in entry 0.
